csi_pkt_builder: RTL

Converts the image sensor's 14-bit pixel stream into a CSI-2 byte stream for the CSI TX FIFO. Per frame it emits: a Frame Start short packet; one RAW14 long packet per line (header, packed payload, CRC footer); a Frame End short packet. It sits between the image sensor model and the CSI FIFO / D-PHY lane serializer.

---
 rtl/csi_pkt_builder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/csi_pkt_builder.sv
// csi_pkt_builder: packs a RAW14 pixel stream into CSI-2 FS / line / FE packets; optional macro CSI_PKT_CRC_EN enables the CRC-16 footer
module csi_pkt_builder #(
  parameter int         IMAGE_LINE_PIXELS = 16,
  parameter int         IMAGE_LINES       = 4,
  parameter logic [1:0] VIRTUAL_CHANNEL   = 2'h0,
  parameter logic [5:0] PIXEL_DATA_TYPE   = 6'h2D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [13:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_eol,
  input  logic        pix_eof,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_sop,
  output logic        byte_eop,
  output logic [15:0] frame_num,
  output logic        err
);
  localparam int PW = $clog2(IMAGE_LINE_PIXELS + 1);
  localparam int LW = $clog2(IMAGE_LINES + 1);
  localparam logic [PW-1:0] NPIX = PW'(IMAGE_LINE_PIXELS);
  localparam logic [PW-1:0] PLAST = PW'(IMAGE_LINE_PIXELS - 1);
  localparam logic [LW-1:0] LLAST = LW'(IMAGE_LINES - 1);
  localparam logic [15:0] WC = 16'(IMAGE_LINE_PIXELS * 14 / 8);
  typedef enum logic [2:0] {IDLE, FS, LH, PAYLOAD, FOOTER, LWAIT, FE} state_t;
  state_t state, state_nxt;
  logic [2:0] bidx, gcnt;
  logic [PW-1:0] pcnt;
  logic [LW-1:0] lcnt;
  logic [13:0] p [4];
  logic eof_l, slot, emit, grp_end, pix_acc, last_pix, pix_err, nxt_sop, nxt_eop;
  logic [7:0] hdr_di, pay, nxt_data;
  logic [15:0] hdr_wc, crc;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // packet sequencing: short/header packets advance as their last byte is loaded, FE waits for its final handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pix_valid && pix_sof) state_nxt = FS;
      FS:      if (emit && bidx == 3'd3) state_nxt = LH;
      LH:      if (emit && bidx == 3'd3) state_nxt = PAYLOAD;
      PAYLOAD: if (grp_end && pcnt == NPIX) state_nxt = FOOTER;
      FOOTER:  if (emit && bidx == 3'd1) state_nxt = eof_l ? FE : LWAIT;
      LWAIT:   if (pix_valid) state_nxt = LH;
      FE:      if (bidx == 3'd4 && byte_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // per-state outputs: pixel acceptance, next byte to load and framing error detection
  always_comb begin
    slot = !byte_valid || byte_ready;
    pix_ready = !rst && ((state == IDLE && !pix_sof) || (state == PAYLOAD && gcnt != 3'd4));
    pix_acc = pix_valid && pix_ready;
    last_pix = pcnt == PLAST;
    emit = slot && ((state inside {FS, LH, FE} && bidx < 3'd4) || (state == PAYLOAD && gcnt == 3'd4) || state == FOOTER);
    grp_end = state == PAYLOAD && emit && bidx == 3'd6;
    hdr_di = {VIRTUAL_CHANNEL, state == LH ? PIXEL_DATA_TYPE : state == FE ? 6'h01 : 6'h00};
    hdr_wc = state == LH ? WC : frame_num;
    pay = bidx == 3'd0 ? p[0][13:6] : bidx == 3'd1 ? p[1][13:6] : bidx == 3'd2 ? p[2][13:6] :
          bidx == 3'd3 ? p[3][13:6] : bidx == 3'd4 ? {p[1][1:0], p[0][5:0]} :
          bidx == 3'd5 ? {p[2][3:0], p[1][5:2]} : {p[3][5:0], p[2][5:4]};
    nxt_data = state == PAYLOAD ? pay : state == FOOTER ? (bidx[0] ? crc[15:8] : crc[7:0]) :
               bidx == 3'd0 ? hdr_di : bidx == 3'd1 ? hdr_wc[7:0] : bidx == 3'd2 ? hdr_wc[15:8] : 8'hCC;
    nxt_sop = state inside {FS, LH, FE} && bidx == 3'd0;
    nxt_eop = (state inside {FS, FE} && bidx == 3'd3) || (state == FOOTER && bidx == 3'd1);
    pix_err = (state == IDLE && pix_valid && !pix_sof) ||
              (state == PAYLOAD && pix_acc && (pix_eol != last_pix || (pix_eof && lcnt != LLAST) ||
               (pix_sof && (lcnt != '0 || pcnt != '0))));
  end
  // output byte register, byte/group/pixel/line counters and frame number
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byte_valid <= 1'b0;
      byte_data <= 8'h00;
      byte_sop <= 1'b0;
      byte_eop <= 1'b0;
      frame_num <= 16'd1;
      err <= 1'b0;
      bidx <= 3'd0;
      gcnt <= 3'd0;
      pcnt <= '0;
      lcnt <= '0;
      eof_l <= 1'b0;
    end else begin
      err <= pix_err;
      bidx <= (state_nxt != state || grp_end) ? 3'd0 : bidx + 3'(emit);
      if (emit) begin
        byte_valid <= 1'b1;
        byte_data <= nxt_data;
        byte_sop <= nxt_sop;
        byte_eop <= nxt_eop;
      end else if (byte_ready) byte_valid <= 1'b0;
      if (state == PAYLOAD && pix_acc) gcnt <= gcnt + 3'd1;
      else if (grp_end) gcnt <= 3'd0;
      if (state == LH) pcnt <= '0;
      else if (state == PAYLOAD && pix_acc) pcnt <= pcnt + PW'(1);
      if (state == FS) lcnt <= '0;
      else if (state == FOOTER && state_nxt != FOOTER) lcnt <= lcnt + LW'(1);
      if (state == FS) eof_l <= 1'b0;
      else if (state == PAYLOAD && pix_acc && last_pix) eof_l <= pix_eof;
      if (state == FE && state_nxt == IDLE) frame_num <= frame_num == 16'hFFFF ? 16'd1 : frame_num + 16'd1;
    end
  // pixel group capture
  always_ff @(posedge clk)
    if (state == PAYLOAD && pix_acc) p[gcnt[1:0]] <= pix_data;
`ifdef CSI_PKT_CRC_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'h8408 : r >> 1;
    return r;
  endfunction
  // CRC restarts at every line header and absorbs each payload byte as it is loaded
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= 16'hFFFF;
    else if (state == LH) crc <= 16'hFFFF;
    else if (state == PAYLOAD && emit) crc <= crc_upd(crc, nxt_data);
`else
  assign crc = 16'h0000;
`endif
endmodule
